// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port synchronous BRAM between two
// req/gnt/rvalid masters with round-robin arbitration. Read data returns one
// cycle after grant. Optional macro BRAM_ARB_RMW_EN turns partial
// (byte-enable) writes into a read-modify-write sequence; without it the byte
// enables are ignored and every write is a single-cycle full-word write.
//
// state  | meaning
// IDLE   | arbitrate requests, issue one BRAM access per cycle
// RMW_WR | write back merged word of a partial write (BRAM_ARB_RMW_EN only)

module bram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    bram_en_o,
    output logic                    bram_we_o,
    output logic [ADDR_WIDTH-1:0]   bram_addr_o,
    output logic [DATA_WIDTH-1:0]   bram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   bram_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    // Depth is informational only; addresses are not range-checked.
    localparam int UNUSED_NUM_WORDS = NUM_WORDS;

`ifdef BRAM_ARB_RMW_EN
    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_e;
`else
    typedef enum logic {IDLE = 1'b0} state_e;
`endif

    state_e                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic                    rvalid_q, rvalid_d;
    logic                    resp_port_q, resp_port_d;
    logic                    resp_we_q, resp_we_d;

    logic                    sel;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_we;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Preferred port wins a tie; a lone requester always wins.
    assign sel       = (p0_req_i && p1_req_i) ? prio_q : p1_req_i;
    assign sel_addr  = sel ? p1_addr_i  : p0_addr_i;
    assign sel_we    = sel ? p1_we_i    : p0_we_i;
    assign sel_wdata = sel ? p1_wdata_i : p0_wdata_i;

    // resp_we_q is kept for visibility of the response type but drives no output.
    logic unused_resp_we;
    assign unused_resp_we = resp_we_q;

`ifdef BRAM_ARB_RMW_EN
    logic [BE_WIDTH-1:0]     sel_be;
    logic [ADDR_WIDTH-1:0]   lat_addr_q;
    logic [BE_WIDTH-1:0]     lat_be_q;
    logic [DATA_WIDTH-1:0]   lat_wdata_q;
    logic                    lat_port_q;
    logic [DATA_WIDTH-1:0]   merged;

    assign sel_be = sel ? p1_be_i : p0_be_i;

    // Merge latched write bytes over the word read back from the BRAM.
    always_comb begin
        merged = bram_rdata_i;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (lat_be_q[i]) merged[i*8 +: 8] = lat_wdata_q[i*8 +: 8];
        end
    end

    // Capture the partial write when entering the write-back state.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && state_d == RMW_WR) begin
            lat_addr_q  <= sel_addr;
            lat_be_q    <= sel_be;
            lat_wdata_q <= sel_wdata;
            lat_port_q  <= sel;
        end
    end
`else
    logic unused_be;
    assign unused_be = ^{p0_be_i, p1_be_i};
`endif

    // Next-state, grant and BRAM drive; everything is suppressed while in reset.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        rvalid_d     = 1'b0;
        resp_port_d  = resp_port_q;
        resp_we_d    = resp_we_q;
        p0_gnt_o     = 1'b0;
        p1_gnt_o     = 1'b0;
        bram_en_o    = 1'b0;
        bram_we_o    = 1'b0;
        bram_addr_o  = '0;
        bram_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (rst_ni && (p0_req_i || p1_req_i)) begin
                    p0_gnt_o     = ~sel;
                    p1_gnt_o     = sel;
                    bram_en_o    = 1'b1;
                    bram_we_o    = sel_we;
                    bram_addr_o  = sel_addr;
                    bram_wdata_o = sel_wdata;
                    prio_d       = ~sel;
                    rvalid_d     = 1'b1;
                    resp_port_d  = sel;
                    resp_we_d    = sel_we;
`ifdef BRAM_ARB_RMW_EN
                    if (sel_we && sel_be != '1) begin
                        // Read the old word now, write the merge next cycle.
                        bram_we_o = 1'b0;
                        rvalid_d  = 1'b0;
                        state_d   = RMW_WR;
                    end
`endif
                end
            end
`ifdef BRAM_ARB_RMW_EN
            RMW_WR: begin
                if (rst_ni) begin
                    bram_en_o    = 1'b1;
                    bram_we_o    = 1'b1;
                    bram_addr_o  = lat_addr_q;
                    bram_wdata_o = merged;
                    rvalid_d     = 1'b1;
                    resp_port_d  = lat_port_q;
                    resp_we_d    = 1'b1;
                end
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, priority and response tracking registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            resp_port_q <= 1'b0;
            resp_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            rvalid_q    <= rvalid_d;
            resp_port_q <= resp_port_d;
            resp_we_q   <= resp_we_d;
        end
    end

    assign p0_rvalid_o = rst_ni && rvalid_q && !resp_port_q;
    assign p1_rvalid_o = rst_ni && rvalid_q &&  resp_port_q;
    assign p0_rdata_o  = bram_rdata_i;
    assign p1_rdata_o  = bram_rdata_i;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural read-first BRAM model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        p0_req, p0_gnt, p0_we, p0_rvalid;
    logic [11:0] p0_addr;
    logic [3:0]  p0_be;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_gnt, p1_we, p1_rvalid;
    logic [11:0] p1_addr;
    logic [3:0]  p1_be;
    logic [31:0] p1_wdata, p1_rdata;
    logic        bram_en, bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_wdata, bram_rdata;

    logic [31:0] mem [0:4095];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
        .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
        .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
        .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata)
    );

    // Single-port BRAM, registered read-first output.
    always @(posedge clk) begin
        if (bram_en) begin
            bram_rdata <= mem[bram_addr];
            if (bram_we) mem[bram_addr] <= bram_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [11:0] a0, a1;
        logic [31:0] d0, d1;
        logic        g0, g1, en, we, v0, v1;
        logic [11:0] addr;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [0:10];

    initial begin
        logic exp_rmw;
`ifdef BRAM_ARB_RMW_EN
        exp_rmw = 1'b1;
`else
        exp_rmw = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h001] = 32'h11111111;
        mem[12'h002] = 32'h22222222;
        mem[12'h005] = 32'hDEADBEEF;
        mem[12'h020] = 32'hAABBCCDD;
        mem[12'h021] = 32'h55667788;
        bram_rdata = 32'h0;

        //            r0 r1 w0 w1 a0      a1      d0            d1            g0 g1 en we v0 v1 addr    chk rd
        vecs[0]  = '{1, 0, 0, 0, 12'h005, 12'h000, 32'h0,        32'h0,        1, 0, 1, 0, 0, 0, 12'h005, 0, 32'h0};
        vecs[1]  = '{0, 0, 0, 0, 12'h000, 12'h000, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 12'h000, 1, 32'hDEADBEEF};
        vecs[2]  = '{1, 1, 0, 0, 12'h001, 12'h002, 32'h0,        32'h0,        0, 1, 1, 0, 0, 0, 12'h002, 0, 32'h0};
        vecs[3]  = '{1, 1, 0, 0, 12'h001, 12'h002, 32'h0,        32'h0,        1, 0, 1, 0, 0, 1, 12'h001, 1, 32'h22222222};
        vecs[4]  = '{1, 1, 0, 0, 12'h001, 12'h002, 32'h0,        32'h0,        0, 1, 1, 0, 1, 0, 12'h002, 1, 32'h11111111};
        vecs[5]  = '{1, 1, 0, 0, 12'h001, 12'h002, 32'h0,        32'h0,        1, 0, 1, 0, 0, 1, 12'h001, 1, 32'h22222222};
        vecs[6]  = '{1, 0, 1, 0, 12'h010, 12'h000, 32'h12345678, 32'h0,        1, 0, 1, 1, 1, 0, 12'h010, 1, 32'h11111111};
        vecs[7]  = '{0, 1, 0, 0, 12'h000, 12'h010, 32'h0,        32'h0,        0, 1, 1, 0, 1, 0, 12'h010, 0, 32'h0};
        vecs[8]  = '{0, 0, 0, 0, 12'h000, 12'h000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 12'h000, 1, 32'h12345678};
        vecs[9]  = '{0, 1, 0, 1, 12'h000, 12'h030, 32'h0,        32'hCAFEF00D, 0, 1, 1, 1, 0, 0, 12'h030, 0, 32'h0};
        vecs[10] = '{0, 0, 0, 0, 12'h000, 12'h000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 12'h000, 0, 32'h0};

        // Reset with both masters requesting: everything must stay quiet.
        rst_ni = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h001; p0_be = 4'hF; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'h002; p1_be = 4'hF; p1_wdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_gnt0", {31'b0, p0_gnt}, 32'd0);
            chk("rst_gnt1", {31'b0, p1_gnt}, 32'd0);
            chk("rst_en",   {31'b0, bram_en}, 32'd0);
            chk("rst_we",   {31'b0, bram_we}, 32'd0);
            chk("rst_rv",   {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
            next_cycle();
        end
        rst_ni = 1'b1;

        for (int v = 0; v < 11; v++) begin
            p0_req = vecs[v].r0; p0_we = vecs[v].we0; p0_addr = vecs[v].a0; p0_wdata = vecs[v].d0;
            p1_req = vecs[v].r1; p1_we = vecs[v].we1; p1_addr = vecs[v].a1; p1_wdata = vecs[v].d1;
            p0_be = 4'hF; p1_be = 4'hF;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", v), {31'b0, p0_gnt}, {31'b0, vecs[v].g0});
            chk($sformatf("v%0d_gnt1", v), {31'b0, p1_gnt}, {31'b0, vecs[v].g1});
            chk($sformatf("v%0d_en", v), {31'b0, bram_en}, {31'b0, vecs[v].en});
            chk($sformatf("v%0d_we", v), {31'b0, bram_we}, {31'b0, vecs[v].we});
            chk($sformatf("v%0d_rv0", v), {31'b0, p0_rvalid}, {31'b0, vecs[v].v0});
            chk($sformatf("v%0d_rv1", v), {31'b0, p1_rvalid}, {31'b0, vecs[v].v1});
            if (vecs[v].en)
                chk($sformatf("v%0d_addr", v), {20'b0, bram_addr}, {20'b0, vecs[v].addr});
            if (vecs[v].chk_rd)
                chk($sformatf("v%0d_rdata", v), vecs[v].v0 ? p0_rdata : p1_rdata, vecs[v].rd);
            next_cycle();
        end
        chk("mem_030", mem[12'h030], 32'hCAFEF00D);

        // Partial write from p0 with p1 requesting during the follow-up cycle.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 12'h020; p0_be = 4'b0010; p0_wdata = 32'h00001100;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 12'h005;
        @(negedge clk);
        chk("pw_t_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("pw_t_we", {31'b0, bram_we}, exp_rmw ? 32'd0 : 32'd1);
        next_cycle();
        p0_req = 1'b0; p0_we = 1'b0; p1_req = 1'b1;
        @(negedge clk);
        if (exp_rmw) begin
            chk("pw_t1_gnt", {30'b0, p0_gnt, p1_gnt}, 32'd0);
            chk("pw_t1_we", {31'b0, bram_we}, 32'd1);
            chk("pw_t1_addr", {20'b0, bram_addr}, 32'h020);
            chk("pw_t1_wdata", bram_wdata, 32'hAABB11DD);
            chk("pw_t1_rv0", {31'b0, p0_rvalid}, 32'd0);
        end else begin
            chk("pw_t1_gnt1", {31'b0, p1_gnt}, 32'd1);
            chk("pw_t1_rv0", {31'b0, p0_rvalid}, 32'd1);
        end
        next_cycle();
        if (!exp_rmw) p1_req = 1'b0;
        @(negedge clk);
        if (exp_rmw) begin
            chk("pw_t2_rv0", {31'b0, p0_rvalid}, 32'd1);
            chk("pw_t2_gnt1", {31'b0, p1_gnt}, 32'd1);
        end else begin
            chk("pw_t2_rv1", {31'b0, p1_rvalid}, 32'd1);
            chk("pw_t2_rdata", p1_rdata, 32'hDEADBEEF);
        end
        next_cycle();
        p1_req = 1'b0;
        next_cycle();
        chk("pw_mem_020", mem[12'h020], exp_rmw ? 32'hAABB11DD : 32'h00001100);

        // Reset lands in the cycle after a partial write grant.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 12'h021; p0_be = 4'b0001; p0_wdata = 32'h000000FF;
        @(negedge clk);
        chk("rr_t_gnt0", {31'b0, p0_gnt}, 32'd1);
        next_cycle();
        rst_ni = 1'b0; p0_req = 1'b0; p0_we = 1'b0;
        @(negedge clk);
        chk("rr_en", {31'b0, bram_en}, 32'd0);
        chk("rr_we", {31'b0, bram_we}, 32'd0);
        chk("rr_rv0", {31'b0, p0_rvalid}, 32'd0);
        next_cycle();
        rst_ni = 1'b1;
        p0_req = 1'b1; p0_addr = 12'h005; p0_be = 4'hF;
        p1_req = 1'b1; p1_addr = 12'h002;
        @(negedge clk);
        chk("rr_post_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("rr_post_gnt1", {31'b0, p1_gnt}, 32'd0);
        chk("rr_post_rv0", {31'b0, p0_rvalid}, 32'd0);
        next_cycle();
        p0_req = 1'b0; p1_req = 1'b0;
        next_cycle();
        chk("rr_mem_021", mem[12'h021], exp_rmw ? 32'h55667788 : 32'h000000FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
